// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit with HI/LO result registers.
//               Executes MULTU/MULT (shift-add) and DIVU/DIV (restoring
//               division) one bit per clock over WIDTH cycles, then writes
//               the results into HI/LO.
//               MTHI/MTLO style writes are accepted while idle.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               start        launch op (accepted only when busy==0)
//               op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//               a, b         operands, sampled with start
//               hi_we/lo_we  write HI/LO from wdata (idle, no start)
//               wdata        HI/LO write data
//               busy         operation in progress
//               done         one-cycle pulse, hi/lo hold fresh results
//               div_by_zero  one-cycle pulse with done for divide by zero
//               hi, lo       result registers
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    // Latched operation context
    logic             is_div;       // op[1] captured at start
    logic             neg_res;      // product / quotient must be negated
    logic             neg_rem;      // remainder must be negated (dividend sign)
    logic [WIDTH-1:0] a_raw;        // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0] opb;          // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc;          // product high half / partial remainder
    logic [WIDTH-1:0] qreg;         // multiplier being consumed / quotient being built
    logic [CW-1:0]    cnt;

    // Operand magnitudes at start: signed ops use op[0]
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Shift-add step: add multiplicand when the current multiplier LSB is set,
    // then shift {carry, acc, qreg} right by one.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc} + (qreg[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

    // Restoring divide step: shift next dividend bit into the partial
    // remainder and subtract the divisor; a borrow (diff MSB) means restore.
    logic [WIDTH:0]   div_part;
    logic [WIDTH:0]   div_diff;
    assign div_part = {acc, qreg[WIDTH-1]};
    assign div_diff = div_part - {1'b0, opb};

    logic [WIDTH-1:0] acc_next, qreg_next;
    always_comb begin
        acc_next  = acc;
        qreg_next = qreg;
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_next  = div_diff[WIDTH-1:0];
                qreg_next = {qreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next  = div_part[WIDTH-1:0];
                qreg_next = {qreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next  = mul_sum[WIDTH:1];
            qreg_next = {mul_sum[0], qreg[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final magnitudes
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;
    logic               dbz_res;

    assign prod_mag = {acc, qreg};
    assign prod_fix = neg_res ? (~prod_mag + 1'b1) : prod_mag;

    always_comb begin
        hi_res  = prod_fix[2*WIDTH-1:WIDTH];
        lo_res  = prod_fix[WIDTH-1:0];
        dbz_res = 1'b0;
        if (is_div) begin
            if (opb == '0) begin
                hi_res  = a_raw;
                lo_res  = '1;
                dbz_res = 1'b1;
            end else begin
                // MIN / -1 wraps naturally to MIN with remainder 0
                lo_res = neg_res ? (~qreg + 1'b1) : qreg;
                hi_res = neg_rem ? (~acc + 1'b1) : acc;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            a_raw       <= '0;
            opb         <= '0;
            acc         <= '0;
            qreg        <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        a_raw   <= a;
                        acc     <= '0;
                        cnt     <= '0;
                        if (op[1]) begin
                            qreg <= a_mag;   // dividend bits shift out MSB-first
                            opb  <= b_mag;
                        end else begin
                            qreg <= b_mag;   // multiplier bits consumed LSB-first
                            opb  <= a_mag;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt  <= cnt + 1'b1;
                    acc  <= acc_next;
                    qreg <= qreg_next;
                end
                FINISH: begin
                    hi          <= hi_res;
                    lo          <= lo_res;
                    done        <= 1'b1;
                    div_by_zero <= dbz_res;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
